// File: rtl/main_memory_responder_if.sv
// Line-request / read-beat / write-beat bundle between a cache miss handler
// (master) and the main memory responder (slave).
interface main_memory_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BEATS  = 4
);
  localparam int BEAT_W = $clog2(BEATS);

  // Every channel is valid/ready: a transfer happens on a rising clock edge
  // where both valid and ready are high; valid never waits for ready.
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [BEAT_W-1:0] resp_beat;
  logic              resp_last;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic              busy;

  modport slave (
    input  req_valid, req_write, req_addr, resp_ready, wr_valid, wr_data,
    output req_ready, resp_valid, resp_data, resp_beat, resp_last,
           wr_ready, wr_done, busy
  );

  modport master (
    output req_valid, req_write, req_addr, resp_ready, wr_valid, wr_data,
    input  req_ready, resp_valid, resp_data, resp_beat, resp_last,
           wr_ready, wr_done, busy
  );
endinterface

// File: rtl/main_memory_responder.sv
// Main memory responder: accepts one cache-line request at a time, waits
// LATENCY cycles, then streams BEATS read words or absorbs BEATS write words.
// Optional macro CRITICAL_WORD_FIRST_EN: read bursts start at the requested
// word and wrap within the line; without it every burst starts at offset 0.
//
// Storage holds (data ^ word_index), so a zero power-up array reads back as
// word i == i without any initialisation pass; reset never touches storage.
module main_memory_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 524288,
  parameter int BEATS   = 4,
  parameter int LATENCY = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  main_memory_responder_if.slave       bus,
  output logic [1:0]                   o_dbg_state
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int LAT_W  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_RD_BURST = 2'd2,
    S_WR_BURST = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [BEAT_W-1:0] r_beat;
  logic [BEAT_W-1:0] r_start;    // first offset of the burst; last beat is the one before it
  logic [IDX_W-1:0]  r_base;
  logic              r_write;
  logic              r_wr_done;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_req_fire;
  logic              w_rd_fire;
  logic              w_wr_fire;
  logic              w_last;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_key;
  logic              w_unused_addr_hi;

  assign w_req_fire = (r_state == S_IDLE) && bus.req_valid;
  assign w_rd_fire  = (r_state == S_RD_BURST) && bus.resp_ready;
  assign w_wr_fire  = (r_state == S_WR_BURST) && bus.wr_valid;
  assign w_last     = (BEAT_W'(r_beat + BEAT_W'(1)) == r_start);
  assign w_idx      = r_base + IDX_W'(r_beat);
  assign w_key      = DATA_W'(w_idx);
  // Address bits above the storage index alias onto the same words.
  assign w_unused_addr_hi = ^bus.req_addr[ADDR_W-1:IDX_W];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          if (LATENCY > 1)        w_next = S_WAIT;
          else if (bus.req_write) w_next = S_WR_BURST;
          else                    w_next = S_RD_BURST;
        end
      end
      S_WAIT: begin
        if (r_lat_cnt == LAT_W'(1)) begin
          if (r_write) w_next = S_WR_BURST;
          else         w_next = S_RD_BURST;
        end
      end
      S_RD_BURST: if (w_rd_fire && w_last) w_next = S_IDLE;
      S_WR_BURST: if (w_wr_fire && w_last) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Request latch, latency countdown, beat counter and write-done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lat_cnt <= '0;
      r_beat    <= '0;
      r_start   <= '0;
      r_base    <= '0;
      r_write   <= 1'b0;
      r_wr_done <= 1'b0;
    end else begin
      r_wr_done <= w_wr_fire && w_last;
      if (w_req_fire) begin
        r_base    <= bus.req_addr[IDX_W-1:0] & ~IDX_W'(BEATS - 1);
        r_write   <= bus.req_write;
        r_lat_cnt <= LAT_W'(LATENCY - 1);
`ifdef CRITICAL_WORD_FIRST_EN
        if (bus.req_write) begin
          r_beat  <= '0;
          r_start <= '0;
        end else begin
          r_beat  <= bus.req_addr[BEAT_W-1:0];
          r_start <= bus.req_addr[BEAT_W-1:0];
        end
`else
        r_beat  <= '0;
        r_start <= '0;
`endif
      end else if (r_state == S_WAIT) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end else if (w_rd_fire || w_wr_fire) begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  // Storage write port; deliberately outside reset so data survives it.
  always_ff @(posedge clock) begin
    if (w_wr_fire) r_mem[w_idx] <= bus.wr_data ^ w_key;
  end

  // Outputs are decoded from state so that reset clears them immediately.
  always_comb begin
    bus.req_ready  = (r_state == S_IDLE);
    bus.resp_valid = (r_state == S_RD_BURST);
    bus.resp_data  = '0;
    bus.resp_beat  = '0;
    bus.resp_last  = 1'b0;
    if (r_state == S_RD_BURST) begin
      bus.resp_data = r_mem[w_idx] ^ w_key;
      bus.resp_beat = r_beat;
      bus.resp_last = w_last;
    end
    bus.wr_ready = (r_state == S_WR_BURST);
    bus.wr_done  = r_wr_done;
    bus.busy     = (r_state != S_IDLE);
  end

  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: line reads with and without
// backpressure, write-back then read-back, async reset mid-burst, aliasing
// and held request during a burst.
module tb_main_memory_responder;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 64;
  localparam int DEPTH     = 524288;
  localparam int BEATS     = 4;
  localparam int LATENCY   = 3;
  localparam int LAT_BOUND = 20;

  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_err;
  int         n_acc;
  logic [63:0] model_mem [int];
  logic [63:0] wdata [BEATS];

  main_memory_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) bus ();

  main_memory_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BEATS(BEATS), .LATENCY(LATENCY)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Request-accept monitor, sampled mid low phase once inputs have settled.
  always @(negedge clock) begin
    #2;
    if (bus.req_valid && bus.req_ready) n_acc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_word(input logic [31:0] a);
    int idx;
    idx = int'(a % DEPTH);
    if (model_mem.exists(idx)) return model_mem[idx];
    return 64'(idx);
  endfunction

  function automatic int first_offset(input logic [31:0] addr);
`ifdef CRITICAL_WORD_FIRST_EN
    return int'(addr % BEATS);
`else
    return 0 * int'(addr[0]);
`endif
  endfunction

  task automatic read_line(input logic [31:0] addr, input int stall_at, input int stall_n,
                           input bit hold_req);
    int lat;
    int acc0;
    int start;
    int off;
    logic [31:0] base;
    base  = addr & ~32'(BEATS - 1);
    start = first_offset(addr);
    acc0  = n_acc;
    @(negedge clock);
    check("rd_req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = addr;
    @(negedge clock);
    if (!hold_req) bus.req_valid = 1'b0;
    check("rd_busy_wait", 64'(bus.busy), 64'd1);
    lat = 1;
    while (!bus.resp_valid && lat < LAT_BOUND) begin
      @(negedge clock);
      lat++;
    end
    check("rd_latency", 64'(lat), 64'(LATENCY));
    for (int k = 0; k < BEATS; k++) begin
      off = (start + k) % BEATS;
      if (k == stall_at) begin
        bus.resp_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check("stall_beat", 64'(bus.resp_beat), 64'(off));
          check("stall_data", bus.resp_data, model_word(base + 32'(off)));
          @(negedge clock);
        end
      end
      if (k == BEATS - 1) bus.req_valid = 1'b0;
      bus.resp_ready = 1'b1;
      check("rd_valid", 64'(bus.resp_valid), 64'd1);
      check("rd_beat", 64'(bus.resp_beat), 64'(off));
      check("rd_data", bus.resp_data, model_word(base + 32'(off)));
      check("rd_last", 64'(bus.resp_last), 64'(k == BEATS - 1));
      @(negedge clock);
    end
    bus.resp_ready = 1'b0;
    check("rd_done_valid", 64'(bus.resp_valid), 64'd0);
    check("rd_done_req_ready", 64'(bus.req_ready), 64'd1);
    check("rd_accepts", 64'(n_acc - acc0), 64'd1);
  endtask

  task automatic write_line(input logic [31:0] addr);
    int lat;
    logic [31:0] base;
    base = addr & ~32'(BEATS - 1);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = addr;
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    lat = 1;
    while (!bus.wr_ready && lat < LAT_BOUND) begin
      @(negedge clock);
      lat++;
    end
    check("wr_latency", 64'(lat), 64'(LATENCY));
    for (int k = 0; k < BEATS; k++) begin
      for (int g = 0; g < k; g++) begin
        bus.wr_valid = 1'b0;
        check("wr_ready_gap", 64'(bus.wr_ready), 64'd1);
        check("wr_done_early", 64'(bus.wr_done), 64'd0);
        @(negedge clock);
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = wdata[k];
      model_mem[int'((base + 32'(k)) % DEPTH)] = wdata[k];
      @(negedge clock);
    end
    bus.wr_valid = 1'b0;
    check("wr_done_pulse", 64'(bus.wr_done), 64'd1);
    check("wr_idle", 64'(bus.req_ready), 64'd1);
    @(negedge clock);
    check("wr_done_clear", 64'(bus.wr_done), 64'd0);
  endtask

  // Reset-state check used at power-up and after the mid-burst reset.
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_resp_data"}, bus.resp_data, 64'd0);
    check({tag, "_resp_beat"}, 64'(bus.resp_beat), 64'd0);
    check({tag, "_resp_last"}, 64'(bus.resp_last), 64'd0);
    check({tag, "_wr_ready"}, 64'(bus.wr_ready), 64'd0);
    check({tag, "_wr_done"}, 64'(bus.wr_done), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_err    = 0;
    n_acc    = 0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // Plain fill of line 2052..2055.
    read_line(32'd2053, -1, 0, 1'b0);
    // Backpressure at beat 1 for two cycles.
    read_line(32'd2053, 1, 2, 1'b0);

    // Stray inputs while idle must not write storage or produce beats.
    @(negedge clock);
    bus.wr_valid   = 1'b1;
    bus.wr_data    = 64'hDEAD;
    bus.resp_ready = 1'b1;
    @(negedge clock);
    check("stray_wr_ready", 64'(bus.wr_ready), 64'd0);
    check("stray_resp_valid", 64'(bus.resp_valid), 64'd0);
    bus.wr_valid   = 1'b0;
    bus.resp_ready = 1'b0;

    // Write-back with gaps, then read it and the neighbouring line.
    for (int k = 0; k < BEATS; k++) wdata[k] = 64'hA0 + 64'(k);
    write_line(32'd64);
    read_line(32'd64, -1, 0, 1'b0);
    read_line(32'd68, -1, 0, 1'b0);
    read_line(32'd2052, -1, 0, 1'b0);

    // Async reset while the third beat of a read is on the bus.
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'd2053;
    @(negedge clock);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < LAT_BOUND) begin
      @(negedge clock);
      lat++;
    end
    check("rst_latency", 64'(lat), 64'(LATENCY));
    bus.resp_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_pre_beat", 64'(bus.resp_beat), 64'((first_offset(32'd2053) + 2) % BEATS));
    check("rst_pre_valid", 64'(bus.resp_valid), 64'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    reset          = 1'b0;
    bus.resp_ready = 1'b0;
    read_line(32'd0, -1, 0, 1'b0);

    // Aliasing above DEPTH, with the request held high through the burst.
    read_line(32'(DEPTH + 8), -1, 0, 1'b1);
    // Mid-line read: wraps from the requested word when critical-word-first is built in.
    read_line(32'd2054, 2, 1, 1'b0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
